// File: rtl/debounce_event_ctrl.sv
// N-channel debouncer with a shared prescaled tick and per-channel stable counters.
// Level changes become events, delivered round-robin over valid/ready. DEBOUNCE_OVF_EN adds sticky event-lost flags.
module debounce_event_ctrl #(
    parameter int N   = 8,
    parameter int CW  = 16,
    parameter int PW  = 16,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           arst,
    input  logic [N-1:0]   raw,
    input  logic [CW-1:0]  thr,
    input  logic [PW-1:0]  prescale,
    output logic [N-1:0]   level,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [IDW-1:0] evt_id,
    output logic           evt_level,
    output logic [N-1:0]   ovf,
    input  logic [N-1:0]   ovf_clr
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t         state, state_n;
    logic [N-1:0]   s1, s, ev, xfer_oh, pending;
    logic [PW-1:0]  pc;
    logic           tick, xfer, load, found;
    logic [CW-1:0]  t_eff;
    logic [IDW-1:0] rr_ptr, grant;
    int             j;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s1 <= '0;
            s  <= '0;
        end else begin
            s1 <= raw;
            s  <= s1;
        end
    end

    // >= compare so a lowered prescale takes effect without waiting for a wrap
    assign tick = (pc >= prescale);

    always_ff @(posedge clk or posedge arst) begin
        if (arst)      pc <= '0;
        else if (tick) pc <= '0;
        else           pc <= pc + PW'(1);
    end

    assign t_eff = (thr == '0) ? CW'(10) : thr;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [CW:0]   cnt_inc;
        logic          lvl;

        assign cnt_inc  = {1'b0, cnt} + (CW+1)'(1);
        assign ev[i]    = tick && (s[i] != lvl) && (cnt_inc >= {1'b0, t_eff});
        assign level[i] = lvl;

        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (tick) begin
                if (s[i] == lvl) begin
                    cnt <= '0;
                end else if (ev[i]) begin
                    lvl <= ~lvl;
                    cnt <= '0;
                end else begin
                    cnt <= cnt_inc[CW-1:0];
                end
            end
        end
    end

    // first pending channel at or after rr_ptr, circular
    always_comb begin
        grant = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N) j = j - N;
            if (!found && pending[j]) begin
                grant = IDW'(j);
                found = 1'b1;
            end
        end
    end

    assign evt_valid = (state == PRESENT);
    assign xfer      = evt_valid && evt_ready;

    always_comb begin
        xfer_oh = '0;
        if (xfer) xfer_oh[evt_id] = 1'b1;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_n = PRESENT;
                    load    = 1'b1;
                end
            end
            PRESENT: begin
                if (evt_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            pending   <= '0;
            rr_ptr    <= '0;
            evt_id    <= '0;
            evt_level <= 1'b0;
        end else begin
            state   <= state_n;
            // a re-raise in the transfer cycle survives the clear
            pending <= (pending & ~xfer_oh) | ev;
            if (load) begin
                evt_id    <= grant;
                evt_level <= level[grant];
            end
            if (xfer) rr_ptr <= (evt_id == IDW'(N-1)) ? '0 : evt_id + IDW'(1);
        end
    end

`ifdef DEBOUNCE_OVF_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) ovf <= '0;
        else      ovf <= (ovf & ~ovf_clr) | (ev & pending & ~xfer_oh);
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ^ovf_clr;
    assign ovf = '0;
`endif

endmodule

// File: tb/tb_debounce_event_ctrl.sv
// Directed bench for debounce_event_ctrl: expected events are queued by stimulus, a monitor pops them on each handshake.
module tb_debounce_event_ctrl;
    localparam int N = 8;

    typedef struct packed {
        logic [2:0] id;
        logic       lvl;
    } ev_t;

    logic         clk = 1'b0;
    logic         arst = 1'b1;
    logic [7:0]   raw = '0;
    logic [15:0]  thr = 16'd3;
    logic [15:0]  prescale = '0;
    logic [7:0]   level;
    logic         evt_valid;
    logic         evt_ready = 1'b1;
    logic [2:0]   evt_id;
    logic         evt_level;
    logic [7:0]   ovf;
    logic [7:0]   ovf_clr = '0;

    int checks = 0;
    int errors = 0;
    ev_t q[$];

`ifdef DEBOUNCE_OVF_EN
    localparam logic [7:0] OVF5 = 8'h20;
`else
    localparam logic [7:0] OVF5 = 8'h00;
`endif

    debounce_event_ctrl #(.N(N), .CW(16), .PW(16)) dut (
        .clk(clk), .arst(arst), .raw(raw), .thr(thr), .prescale(prescale),
        .level(level), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_id(evt_id), .evt_level(evt_level), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [2:0] id, input logic lvl);
        ev_t e;
        e.id  = id;
        e.lvl = lvl;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!arst && evt_valid && evt_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got id %0d level %0d expected none", evt_id, evt_level);
            end else begin
                e = q.pop_front();
                check("evt_id", 32'(evt_id), 32'(e.id));
                check("evt_level", 32'(evt_level), 32'(e.lvl));
            end
        end
    end

    initial begin
        #2;
        check("rst_level", 32'(level), 0);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_ovf", 32'(ovf), 0);
        cyc(3);
        arst = 1'b0;
        cyc(3);

        // single rise, exact latency k+1+T with T=3
        expect_ev(3'd0, 1'b1);
        raw = 8'h01;
        cyc(4);
        check("lat_before", 32'(level[0]), 0);
        cyc(1);
        check("lat_at", 32'(level[0]), 1);
        cyc(6);
        check("single_q_empty", 32'(q.size()), 0);
        check("single_ovf", 32'(ovf), 0);

        // two-cycle glitch is rejected
        raw = 8'h05;
        cyc(2);
        raw = 8'h01;
        cyc(10);
        check("glitch_level", 32'(level), 32'h01);

        // fall ch0 so rr_ptr=1, then simultaneous ch1/ch3 -> 1 then 3
        expect_ev(3'd0, 1'b0);
        raw = 8'h00;
        cyc(10);
        expect_ev(3'd1, 1'b1);
        expect_ev(3'd3, 1'b1);
        raw = 8'h0A;
        cyc(12);
        check("simul_level", 32'(level), 32'h0A);
        // rr_ptr=4: ch0 rise wins over ch1 fall via wrap
        expect_ev(3'd0, 1'b1);
        expect_ev(3'd1, 1'b0);
        raw = 8'h09;
        cyc(12);
        check("wrap_q_empty", 32'(q.size()), 0);

        // backpressure: ch5 toggles three times, one event, overflow
        thr = 16'd1;
        evt_ready = 1'b0;
        raw = 8'h29;
        cyc(4);
        raw = 8'h09;
        cyc(4);
        raw = 8'h29;
        cyc(6);
        check("bp_valid", 32'(evt_valid), 1);
        check("bp_id", 32'(evt_id), 5);
        check("bp_level_stale", 32'(evt_level), 1);
        check("bp_ovf", 32'(ovf), 32'(OVF5));
        expect_ev(3'd5, 1'b1);
        evt_ready = 1'b1;
        cyc(5);
        check("bp_q_empty", 32'(q.size()), 0);
        check("bp_ovf_hold", 32'(ovf), 32'(OVF5));
        ovf_clr = 8'h20;
        cyc(1);
        ovf_clr = 8'h00;
        cyc(1);
        check("ovf_cleared", 32'(ovf), 0);

        // default threshold 10 ticks, tick every 4 cycles
        thr = 16'd0;
        prescale = 16'd3;
        expect_ev(3'd7, 1'b1);
        raw = 8'hA9;
        cyc(36);
        check("t10_before", 32'(level[7]), 0);
        cyc(8);
        check("t10_after", 32'(level[7]), 1);
        cyc(4);
        check("t10_q_empty", 32'(q.size()), 0);

        // reset while presenting with three pending
        thr = 16'd1;
        prescale = 16'd0;
        evt_ready = 1'b0;
        raw = 8'hBF;
        cyc(6);
        check("pre_rst_valid", 32'(evt_valid), 1);
        arst = 1'b1;
        raw = 8'h00;
        #1;
        check("arst_level", 32'(level), 0);
        check("arst_valid", 32'(evt_valid), 0);
        check("arst_id", 32'(evt_id), 0);
        check("arst_evt_level", 32'(evt_level), 0);
        check("arst_ovf", 32'(ovf), 0);
        cyc(3);
        arst = 1'b0;
        evt_ready = 1'b1;
        cyc(20);
        check("post_rst_valid", 32'(evt_valid), 0);
        check("post_rst_level", 32'(level), 0);
        check("final_q_empty", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
